uart_mmio_q: RTL and testbench
==============================

# uart_mmio_q

Memory-mapped register front-end for the UART core, replacing the fixed 16-word register bank with a parametrised peripheral. It adds a transmit queue in front of the UART TX FIFO, single-write RX pop, sticky error flags, and a maskable level interrupt. It sits between the CPU data-memory port (word-addressed `addra`/`dina`/`douta`, write strobe `wea`) and the UART core's FIFO handshake.

## Interface
Parameters:
- `DATA_W`, 8: UART character width; 1..BUS_W-16.
- `BUS_W`, 32: CPU data bus width.
- `TXQ_DEPTH`, 16: transmit queue entries; power of two, ≥2. `CW = clog2(TXQ_DEPTH)+1`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wea`  in  1  CPU write strobe.
- `addra`  in  4  word address.
- `dina`  in  BUS_W  write data.
- `douta`  out  BUS_W  registered read data.
- `irq`  out  1  level interrupt.
- `rx_fifo_flush_enable`  out  1  one-cycle RX flush pulse to the UART core.
- `rd_uart`  out  1  RX pop strobe.
- `wr_uart`  out  1  TX push strobe.
- `w_data`  out  DATA_W  TX character.
- `tx_full`  in  1  UART TX FIFO full.
- `rx_empty`  in  1  UART RX FIFO empty.
- `r_data`  in  DATA_W  UART RX head character.

## Operation
Register map (unlisted addresses 8–15 read 0; writes to them are ignored):
- 0 STATUS (RO): bit0 rx_empty, bit1 tx_full, bit2 txq_empty, bit3 txq_full, bit4 any error flag set, bits[8+CW-1:8] txq count.
- 1 RXPOP (WO): any write pulses `rd_uart` for one cycle if `rx_empty`=0. If `rx_empty`=1, no pulse; sets ERR.rx_underflow.
- 2 RXDATA (RO): zero-extended `r_data`.
- 3 TXDATA (WO): pushes `dina[DATA_W-1:0]` into txq. If the queue is full, the write is dropped and ERR.tx_overflow is set.
- 4 TXCOUNT (RO): txq count, zero-extended.
- 5 IRQ_EN (RW, bits[2:0]): bit0 rx data available, bit1 txq empty, bit2 error.
- 6 ERR (RW1C): bit0 tx_overflow, bit1 rx_underflow. Flags are sticky. Writing 1 clears a flag; writing 0 leaves it unchanged.
- 7 CTRL (RW bit0, self-clearing bits 1–2):
  - bit0 tx_enable.
  - bit1 rx_flush: pulses `rx_fifo_flush_enable` for one cycle; reads 0.
  - bit2 txq_flush: empties txq; reads 0.

TX queue:
- Circular buffer with `TXQ_DEPTH` entries, read and write pointers, and a CW-bit count. Pointers wrap modulo depth.
- `wr_uart = tx_enable & ~txq_empty & ~tx_full` (combinational).
- `w_data` = queue head when not empty, otherwise 0.
- Each `wr_uart` cycle pops one entry.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- Full is judged on the pre-edge count. A push while full is dropped even if a pop occurs in the same cycle.
- txq_flush takes priority over a same-cycle push or pop: the count becomes 0 and the pushed data is discarded.

Interrupt:
- `irq = (en0 & ~rx_empty) | (en1 & txq_empty) | (en2 & (tx_overflow | rx_underflow))`, registered.
- A same-cycle set and W1C of the same ERR flag leaves the flag set.

Reset (asynchronous, `rst`=1):
- `douta`, `irq`, `rd_uart`, and `rx_fifo_flush_enable` are 0.
- IRQ_EN, ERR, CTRL, pointers, and count are 0.
- Consequently `wr_uart`=0 and `w_data`=0.
- Queue storage is not cleared.
- Reset mid-transfer discards queued characters without issuing further `wr_uart`.

## Timing
- Read latency is 1 cycle: `douta` at edge N+1 shows the register state sampled at edge N for the `addra` present at edge N. Read has no side effects.
- A write at edge N is visible on a read issued at edge N+1 or later.
- `rd_uart` and `rx_fifo_flush_enable` assert in the cycle after the write edge, for exactly one cycle. Back-to-back RXPOP writes produce back-to-back pulses.
- TXDATA write at edge N, with tx_enable=1 and `tx_full`=0: `wr_uart` is high in cycle N+1.
- Sustained drain rate is one character per cycle while `tx_full`=0.
- `irq` lags its sources by one cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; STATUS reads 0x0000_0005 with `rx_empty`=1 and `tx_full`=0.
- TX burst, TXQ_DEPTH=16, tx_enable=0:
  - Write 0x41..0x50 (16 chars), then a 17th write 0x51 → TXCOUNT=16, STATUS bit3=1, ERR=0x1.
  - Set tx_enable → `wr_uart` high for 16 cycles carrying 0x41..0x50 in order; 0x51 is never sent.
- Backpressure: drive `tx_full`=1 for 5 cycles mid-burst → no `wr_uart` and no data loss; resumes with the next character when `tx_full` drops.
- RX path:
  - `rx_empty`=0, `r_data`=0x5A → RXDATA reads 0x5A; RXPOP write gives a single 1-cycle `rd_uart`.
  - RXPOP with `rx_empty`=1 → no pulse, ERR=0x2.
  - W1C 0x2 → ERR=0.
- IRQ: IRQ_EN=0x2, queue empty → `irq`=1; push one char with tx_enable=0 → `irq`=0 one cycle later; txq_flush → count 0, `irq`=1.
- Simultaneous events:
  - Push while draining at count 16 → dropped, overflow set.
  - Push while draining at count 3 → count stays 3.
  - ERR set and W1C in the same cycle → flag remains 1.

Source files
------------

// File: rtl/uart_mmio_q_if.sv
// Bus bundle between the CPU data-memory port / UART core FIFO handshake and uart_mmio_q.
interface uart_mmio_q_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BUS_W  = 32
);
  // CPU side
  logic              wea;
  logic [3:0]        addra;
  logic [BUS_W-1:0]  dina;
  logic [BUS_W-1:0]  douta;
  logic              irq;
  // UART core side
  logic              rx_fifo_flush_enable;
  logic              rd_uart;
  logic              wr_uart;
  logic [DATA_W-1:0] w_data;
  logic              tx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] r_data;

  modport slave (
    input  wea, addra, dina, tx_full, rx_empty, r_data,
    output douta, irq, rx_fifo_flush_enable, rd_uart, wr_uart, w_data
  );

  modport master (
    output wea, addra, dina, tx_full, rx_empty, r_data,
    input  douta, irq, rx_fifo_flush_enable, rd_uart, wr_uart, w_data
  );
endinterface

// File: rtl/uart_mmio_q.sv
// Memory-mapped UART front-end: TX queue, RX pop strobe, sticky W1C errors, level irq.
module uart_mmio_q #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned TXQ_DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  uart_mmio_q_if.slave bus
);
  localparam int unsigned PW = $clog2(TXQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [3:0] AddrStatus  = 4'd0;
  localparam logic [3:0] AddrRxPop   = 4'd1;
  localparam logic [3:0] AddrRxData  = 4'd2;
  localparam logic [3:0] AddrTxData  = 4'd3;
  localparam logic [3:0] AddrTxCount = 4'd4;
  localparam logic [3:0] AddrIrqEn   = 4'd5;
  localparam logic [3:0] AddrErr     = 4'd6;
  localparam logic [3:0] AddrCtrl    = 4'd7;

  // Queue storage is deliberately left out of reset.
  logic [DATA_W-1:0] txq_mem [TXQ_DEPTH];

  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             tx_en_q, tx_en_d;
  logic [2:0]       irq_en_q, irq_en_d;
  logic [1:0]       err_q, err_d;
  logic             rd_uart_q, rd_uart_d;
  logic             rx_flush_q, rx_flush_d;
  logic             irq_q, irq_d;
  logic [BUS_W-1:0] douta_q, rdata;

  logic txq_empty, txq_full, push, pop, txq_flush;
  logic wr_rxpop, wr_txdata, wr_irqen, wr_err, wr_ctrl;
  logic unused_dina;

  assign wr_rxpop  = bus.wea & (bus.addra == AddrRxPop);
  assign wr_txdata = bus.wea & (bus.addra == AddrTxData);
  assign wr_irqen  = bus.wea & (bus.addra == AddrIrqEn);
  assign wr_err    = bus.wea & (bus.addra == AddrErr);
  assign wr_ctrl   = bus.wea & (bus.addra == AddrCtrl);

  assign txq_empty = (count_q == '0);
  assign txq_full  = (count_q == CW'(TXQ_DEPTH));
  assign pop       = tx_en_q & ~txq_empty & ~bus.tx_full;
  // Fullness is judged before the edge, so a same-cycle pop cannot rescue a push.
  assign push      = wr_txdata & ~txq_full;
  assign txq_flush = wr_ctrl & bus.dina[2];

  assign unused_dina = ^bus.dina[BUS_W-1:DATA_W];

  // Next-state for queue pointers, control registers, sticky errors and pulses.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (txq_flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (push) wptr_d = wptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    irq_en_d = wr_irqen ? bus.dina[2:0] : irq_en_q;
    tx_en_d  = wr_ctrl ? bus.dina[0] : tx_en_q;

    // Clear first, then set, so a coincident set wins over W1C.
    err_d = err_q & ~(wr_err ? bus.dina[1:0] : 2'b00);
    if (wr_txdata & txq_full)   err_d[0] = 1'b1;
    if (wr_rxpop & bus.rx_empty) err_d[1] = 1'b1;

    rd_uart_d  = wr_rxpop & ~bus.rx_empty;
    rx_flush_d = wr_ctrl & bus.dina[1];
    irq_d      = (irq_en_q[0] & ~bus.rx_empty) | (irq_en_q[1] & txq_empty) |
                 (irq_en_q[2] & (|err_q));
  end

  // Read mux over the register state as it stands before the edge.
  always_comb begin
    rdata = '0;
    unique case (bus.addra)
      AddrStatus: begin
        rdata[0]      = bus.rx_empty;
        rdata[1]      = bus.tx_full;
        rdata[2]      = txq_empty;
        rdata[3]      = txq_full;
        rdata[4]      = |err_q;
        rdata[8 +: CW] = count_q;
      end
      AddrRxData:  rdata[DATA_W-1:0] = bus.r_data;
      AddrTxCount: rdata[CW-1:0]     = count_q;
      AddrIrqEn:   rdata[2:0]        = irq_en_q;
      AddrErr:     rdata[1:0]        = err_q;
      AddrCtrl:    rdata[0]          = tx_en_q;
      default:     rdata             = '0;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      tx_en_q    <= 1'b0;
      irq_en_q   <= '0;
      err_q      <= '0;
      rd_uart_q  <= 1'b0;
      rx_flush_q <= 1'b0;
      irq_q      <= 1'b0;
      douta_q    <= '0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
      err_q      <= err_d;
      rd_uart_q  <= rd_uart_d;
      rx_flush_q <= rx_flush_d;
      irq_q      <= irq_d;
      douta_q    <= rdata;
    end
  end

  // Queue storage write; a flush discards the coincident push.
  always_ff @(posedge clk) begin
    if (push & ~txq_flush) txq_mem[wptr_q] <= bus.dina[DATA_W-1:0];
  end

  assign bus.douta                = douta_q;
  assign bus.irq                  = irq_q;
  assign bus.rd_uart              = rd_uart_q;
  assign bus.rx_fifo_flush_enable = rx_flush_q;
  assign bus.wr_uart              = pop;
  assign bus.w_data               = txq_empty ? '0 : txq_mem[rptr_q];
endmodule

// File: tb/tb_uart_mmio_q.sv
// Self-checking bench for uart_mmio_q: directed scenarios plus randomized traffic vs a queue model.
module tb_uart_mmio_q;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_tx_en;
  logic [1:0] m_err;
  logic [2:0] m_irq_en;

  uart_mmio_q_if #(.DATA_W(8), .BUS_W(32)) bus ();

  uart_mmio_q #(.DATA_W(8), .BUS_W(32), .TXQ_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.wea = 1'b1; bus.addra = a; bus.dina = d;
    tick();
    bus.wea = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bus.addra = a;
    tick();
    d = bus.douta;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int v;
    v = 0;
    case (a)
      4'd0: v = (q.size() << 8) | ((m_err != 0) << 4) | ((q.size() == DEPTH) << 3) |
                ((q.size() == 0) << 2) | (bus.tx_full << 1) | bus.rx_empty;
      4'd2: v = bus.r_data;
      4'd4: v = q.size();
      4'd5: v = m_irq_en;
      4'd6: v = m_err;
      4'd7: v = m_tx_en;
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    bus.wea = 0; bus.addra = 0; bus.dina = 0;
    bus.tx_full = 0; bus.rx_empty = 1; bus.r_data = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_write(4'd5, 32'h2);
    do_write(4'd3, 32'h33);
    do_write(4'd7, 32'h1);
    do_read(4'd7, d);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.douta, bus.irq, bus.rd_uart, bus.rx_fifo_flush_enable, bus.wr_uart, bus.w_data}
        !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: douta=%h irq=%b rd=%b fl=%b wr=%b wd=%h, required all 0",
               bus.douta, bus.irq, bus.rd_uart, bus.rx_fifo_flush_enable, bus.wr_uart,
               bus.w_data);
    end
    #2 rst = 1'b0;
    q.delete(); m_tx_en = 0; m_err = 0; m_irq_en = 0;
    #1;
    n_vec++;
    if (bus.wr_uart !== 1'b0) begin
      n_miss++; $display("FAIL reset_no_wr: wr_uart=%b required 0", bus.wr_uart);
    end
    do_read(4'd0, d);
    n_vec++;
    if (d !== 32'h5) begin n_miss++; $display("FAIL reset_status: got %h required 5", d); end
    for (int a = 4; a < 8; a++) begin
      do_read(a[3:0], d);
      n_vec++;
      if (d !== 32'h0) begin
        n_miss++; $display("FAIL reset_reg%0d: got %h required 0", a, d);
      end
    end
  endtask

  task automatic test_tx_burst();
    logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(4'd3, 32'h41 + i);
      q.push_back(8'(8'h41 + i));
    end
    do_write(4'd3, 32'h51);
    do_read(4'd4, d);
    n_vec++;
    if (d !== 32'd16) begin n_miss++; $display("FAIL burst_count: got %0d required 16", d); end
    do_read(4'd0, d);
    n_vec++;
    if (d !== 32'h1019) begin n_miss++; $display("FAIL burst_status: got %h required 1019", d); end
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h1) begin n_miss++; $display("FAIL burst_err: got %h required 1", d); end
    do_write(4'd7, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if ({bus.wr_uart, bus.w_data} !== {1'b1, q[0]}) begin
        n_miss++;
        $display("FAIL burst_drain%0d: wr=%b data=%h required wr=1 data=%h", i, bus.wr_uart,
                 bus.w_data, q[0]);
      end
      tick();
      void'(q.pop_front());
    end
    n_vec++;
    if (bus.wr_uart !== 1'b0) begin
      n_miss++; $display("FAIL burst_stop: wr_uart=%b required 0", bus.wr_uart);
    end
    do_write(4'd6, 32'h1);
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h0) begin n_miss++; $display("FAIL burst_w1c: got %h required 0", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [7:0]  c;
    do_write(4'd7, 32'h0);
    for (int i = 0; i < 8; i++) begin
      c = 8'($urandom);
      do_write(4'd3, {24'h0, c});
      q.push_back(c);
    end
    do_write(4'd7, 32'h1);
    for (int i = 0; i < 13; i++) begin
      if (i == 3) begin bus.tx_full = 1'b1; #1; end
      if (i == 8) begin bus.tx_full = 1'b0; #1; end
      n_vec++;
      if ({bus.wr_uart, bus.w_data} !== {(i < 3 || i >= 8), q[0]}) begin
        n_miss++;
        $display("FAIL bp_cycle%0d: wr=%b data=%h required wr=%b data=%h", i, bus.wr_uart,
                 bus.w_data, (i < 3 || i >= 8), q[0]);
      end
      tick();
      if (i < 3 || i >= 8) void'(q.pop_front());
    end
    do_read(4'd4, d);
    n_vec++;
    if (d !== 32'h0) begin n_miss++; $display("FAIL bp_count: got %0d required 0", d); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    bus.rx_empty = 1'b0; bus.r_data = 8'h5A;
    do_read(4'd2, d);
    n_vec++;
    if (d !== 32'h5A) begin n_miss++; $display("FAIL rx_data: got %h required 5a", d); end
    do_write(4'd1, 32'h0);
    n_vec++;
    if (bus.rd_uart !== 1'b1) begin n_miss++; $display("FAIL rx_pop: rd=%b required 1", bus.rd_uart); end
    tick();
    n_vec++;
    if (bus.rd_uart !== 1'b0) begin n_miss++; $display("FAIL rx_pop_end: rd=%b required 0", bus.rd_uart); end
    bus.wea = 1'b1; bus.addra = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) bus.wea = 1'b0;
      n_vec++;
      if (bus.rd_uart !== (i < 2)) begin
        n_miss++; $display("FAIL rx_b2b%0d: rd=%b required %b", i, bus.rd_uart, (i < 2));
      end
    end
    bus.rx_empty = 1'b1;
    do_write(4'd1, 32'h0);
    n_vec++;
    if (bus.rd_uart !== 1'b0) begin n_miss++; $display("FAIL rx_under_pulse: rd=%b required 0", bus.rd_uart); end
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h2) begin n_miss++; $display("FAIL rx_under_err: got %h required 2", d); end
    do_write(4'd6, 32'h2);
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h0) begin n_miss++; $display("FAIL rx_w1c: got %h required 0", d); end
    do_write(4'd7, 32'h2);
    m_tx_en = 0;
    n_vec++;
    if (bus.rx_fifo_flush_enable !== 1'b1) begin
      n_miss++; $display("FAIL rx_flush: fl=%b required 1", bus.rx_fifo_flush_enable);
    end
    do_read(4'd7, d);
    n_vec++;
    if ({bus.rx_fifo_flush_enable, d} !== 33'h0) begin
      n_miss++; $display("FAIL rx_flush_end: fl=%b ctrl=%h required 0/0", bus.rx_fifo_flush_enable, d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_write(4'd5, 32'h2);
    n_vec++;
    if (bus.irq !== 1'b0) begin n_miss++; $display("FAIL irq_lag: irq=%b required 0", bus.irq); end
    tick();
    n_vec++;
    if (bus.irq !== 1'b1) begin n_miss++; $display("FAIL irq_empty: irq=%b required 1", bus.irq); end
    do_write(4'd3, 32'h77);
    tick();
    n_vec++;
    if (bus.irq !== 1'b0) begin n_miss++; $display("FAIL irq_push: irq=%b required 0", bus.irq); end
    do_write(4'd7, 32'h4);
    do_read(4'd4, d);
    n_vec++;
    if ({bus.irq, d} !== {1'b1, 32'h0}) begin
      n_miss++; $display("FAIL irq_flush: irq=%b count=%0d required 1/0", bus.irq, d);
    end
    do_write(4'd5, 32'h1);
    bus.rx_empty = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (bus.irq !== 1'b1) begin n_miss++; $display("FAIL irq_rx: irq=%b required 1", bus.irq); end
    bus.rx_empty = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (bus.irq !== 1'b0) begin n_miss++; $display("FAIL irq_rx_off: irq=%b required 0", bus.irq); end
    do_write(4'd5, 32'h4);
    do_write(4'd1, 32'h0);
    tick();
    n_vec++;
    if (bus.irq !== 1'b1) begin n_miss++; $display("FAIL irq_err: irq=%b required 1", bus.irq); end
    do_write(4'd6, 32'h2);
    tick();
    n_vec++;
    if (bus.irq !== 1'b0) begin n_miss++; $display("FAIL irq_err_clr: irq=%b required 0", bus.irq); end
    do_write(4'd5, 32'h0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [7:0]  c;
    int          n;
    for (int pass = 0; pass < 2; pass++) begin
      n = (pass == 0) ? DEPTH : 3;
      do_write(4'd7, 32'h0);
      for (int i = 0; i < n; i++) begin
        c = 8'($urandom);
        do_write(4'd3, {24'h0, c});
        q.push_back(c);
      end
      bus.tx_full = 1'b1;
      do_write(4'd7, 32'h1);
      bus.tx_full = 1'b0;
      c = 8'($urandom);
      bus.wea = 1'b1; bus.addra = 4'd3; bus.dina = {24'h0, c};
      tick();
      bus.tx_full = 1'b1; bus.wea = 1'b0;
      #1;
      void'(q.pop_front());
      if (n != DEPTH) q.push_back(c);
      do_read(4'd4, d);
      n_vec++;
      if (d !== q.size()) begin
        n_miss++; $display("FAIL simul_count%0d: got %0d required %0d", pass, d, q.size());
      end
      do_read(4'd6, d);
      n_vec++;
      if (d !== (n == DEPTH)) begin
        n_miss++; $display("FAIL simul_err%0d: got %h required %h", pass, d, (n == DEPTH));
      end
      bus.tx_full = 1'b0;
      #1;
      while (q.size() > 0) begin
        n_vec++;
        if ({bus.wr_uart, bus.w_data} !== {1'b1, q[0]}) begin
          n_miss++;
          $display("FAIL simul_drain%0d: wr=%b data=%h required wr=1 data=%h", pass,
                   bus.wr_uart, bus.w_data, q[0]);
        end
        tick();
        void'(q.pop_front());
      end
      n_vec++;
      if (bus.wr_uart !== 1'b0) begin
        n_miss++; $display("FAIL simul_stop%0d: wr=%b required 0", pass, bus.wr_uart);
      end
      do_write(4'd6, 32'h3);
    end
    // Selective W1C: clearing one flag leaves the other set.
    do_write(4'd7, 32'h0);
    for (int i = 0; i <= DEPTH; i++) do_write(4'd3, 32'($urandom));
    do_write(4'd1, 32'h0);
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h3) begin n_miss++; $display("FAIL w1c_both: got %h required 3", d); end
    do_write(4'd6, 32'h2);
    do_read(4'd6, d);
    n_vec++;
    if (d !== 32'h1) begin n_miss++; $display("FAIL w1c_partial: got %h required 1", d); end
    do_write(4'd7, 32'h4);
    do_write(4'd6, 32'h1);
    do_read(4'd0, d);
    n_vec++;
    if (d !== 32'h5) begin n_miss++; $display("FAIL w1c_status: got %h required 5", d); end
    m_tx_en = 0; m_err = 0;
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] d, exp_rd;
    logic [3:0]  a;
    logic        w, exp_irq, exp_fl, irq_n, full_pre, pop;
    m_irq_en = 3'($urandom_range(0, 7));
    do_write(4'd5, {29'h0, m_irq_en});
    bus.rx_empty = 1'b1;
    repeat (2) tick();
    exp_irq = m_irq_en[1];
    exp_fl  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op = $urandom_range(0, 5);
      d  = $urandom;
      w  = 1'b1;
      case (op)
        1: a = 4'd3;
        2: begin a = 4'd7; d = {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom)}; end
        3: begin a = 4'd4; w = 1'b0; end
        4: begin a = 4'd0; w = 1'b0; end
        5: a = 4'd6;
        default: begin a = 4'(8 + $urandom_range(0, 7)); w = 1'($urandom); end
      endcase
      bus.wea = w; bus.addra = a; bus.dina = d;
      bus.tx_full  = ($urandom_range(0, 3) == 0);
      bus.rx_empty = 1'($urandom);
      bus.r_data   = 8'($urandom);
      #1;
      pop = m_tx_en && q.size() > 0 && !bus.tx_full;
      n_vec++;
      if ({bus.wr_uart, bus.w_data} !== {pop, (q.size() > 0) ? q[0] : 8'h0}) begin
        n_miss++;
        $display("FAIL rnd_tx%0d: wr=%b data=%h required wr=%b data=%h", cyc, bus.wr_uart,
                 bus.w_data, pop, (q.size() > 0) ? q[0] : 8'h0);
      end
      n_vec++;
      if ({bus.irq, bus.rx_fifo_flush_enable, bus.rd_uart} !== {exp_irq, exp_fl, 1'b0}) begin
        n_miss++;
        $display("FAIL rnd_pulse%0d: irq=%b fl=%b rd=%b required %b/%b/0", cyc, bus.irq,
                 bus.rx_fifo_flush_enable, bus.rd_uart, exp_irq, exp_fl);
      end
      exp_rd   = model_read(a);
      irq_n    = (m_irq_en[0] && !bus.rx_empty) || (m_irq_en[1] && q.size() == 0) ||
                 (m_irq_en[2] && m_err != 0);
      full_pre = (q.size() == DEPTH);
      exp_fl   = (op == 2) && d[1];
      if (op == 5) m_err = m_err & ~d[1:0];
      if (op == 1 && full_pre) m_err[0] = 1'b1;
      if (op == 2 && d[2]) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (op == 1 && !full_pre) q.push_back(d[7:0]);
      end
      if (op == 2) m_tx_en = d[0];
      exp_irq = irq_n;
      tick();
      n_vec++;
      if (bus.douta !== exp_rd) begin
        n_miss++;
        $display("FAIL rnd_read%0d: addr=%0d got %h required %h", cyc, a, bus.douta, exp_rd);
      end
    end
    bus.wea = 1'b0;
  endtask

  initial begin
    q.delete(); m_tx_en = 0; m_err = 0; m_irq_en = 0;
    test_reset();
    test_tx_burst();
    test_backpressure();
    test_rx();
    test_irq();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
